uart_rx: RTL and testbench

Serial receiver paired with the UART transmitter in the peripheral's datapath. It consumes the serial line (the transmitter's output in loopback, the external pin in normal use) and recovers 8N1 frames using the same runtime CLKS_PER_BIT divisor. Each completed frame produces one byte and a single-cycle valid pulse toward the register/FIFO side. It also flags framing errors and stays quiet through glitches and line breaks.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 30 +++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the peripheral datapath.
// Holds the receiver and transmitter state encodings, the frame shape
// (8 data bits, 1 stop bit), the default divisor floor, and a helper
// that applies that floor to a runtime clocks-per-bit value.
package uart_pkg;

   localparam int DATA_BITS    = 8;
   localparam int STOP_BITS    = 1;
   localparam int FRAME_BITS   = 1 + DATA_BITS + STOP_BITS;
   localparam int CNT_W        = 16;
   localparam int UART_MIN_CPB = 4;

   typedef enum logic [2:0] {
      RX_IDLE     = 3'd0,
      RX_START    = 3'd1,
      RX_DATA     = 3'd2,
      RX_STOP     = 3'd3,
      RX_BRK_WAIT = 3'd4
   } rx_state_e;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   // Divisors below the floor leave no room for a mid-bit sample point.
   function automatic logic [CNT_W-1:0] clamp_cpb(input logic [CNT_W-1:0] cpb,
                                                 input logic [CNT_W-1:0] floor_cpb);
      return (cpb < floor_cpb) ? floor_cpb : cpb;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop bit synchronizer for a single asynchronous input.
// Ports:
//   clk_i  - destination clock
//   rst_i  - synchronous active-high reset; all stages load RST_VAL
//   d_i    - asynchronous input
//   q_o    - synchronized output (last stage)
// STAGES must be at least 2.
module sync_2ff #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver.
// Recovers frames from i_RX_Serial using a divisor latched at start-bit
// detection, emits one byte per frame with a single-cycle valid pulse,
// flags a low stop bit as a framing error, rejects short start glitches,
// and waits out a held-low line (break) before re-arming.
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   rx_en          - gates acceptance of new start bits only
//   i_RX_Serial    - asynchronous serial line, idles high
//   CLKS_PER_BIT   - runtime divisor, floored at MIN_CPB
//   o_RX_Byte      - last received byte, held until the next valid
//   o_RX_Valid     - one-cycle pulse when o_RX_Byte updates
//   o_Frame_Err    - one-cycle pulse with o_RX_Valid when stop bit was 0
//   o_RX_Busy      - high whenever the receiver is not idle
//
// state       | meaning
// ------------+---------------------------------------------------------
// RX_IDLE     | line idle, waiting for a low level while rx_en is high
// RX_START    | timing to mid start bit; high there means glitch
// RX_DATA     | sampling 8 data bits at mid-bit, LSB first
// RX_STOP     | sampling stop bit, then publishing byte and status
// RX_BRK_WAIT | stop bit was low; wait for line to return high
module uart_rx
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_CPB     = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rx_en,
   input  logic        i_RX_Serial,
   input  logic [15:0] CLKS_PER_BIT,
   output logic [7:0]  o_RX_Byte,
   output logic        o_RX_Valid,
   output logic        o_Frame_Err,
   output logic        o_RX_Busy
);

   localparam logic [CNT_W-1:0] CPB_FLOOR = CNT_W'(MIN_CPB);
   localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

   logic             rxs;
   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cpb_q, cpb_d;
   logic [CNT_W-1:0] cpb_new;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       byte_q, byte_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   sync_2ff #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_sync_rx (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (i_RX_Serial),
      .q_o   (rxs)
   );

   assign cpb_new = clamp_cpb(CLKS_PER_BIT, CPB_FLOOR);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         cpb_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cpb_q   <= cpb_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // cnt_q is a down-counter; each phase loads its length minus one and
   // acts when it reaches zero, which lands the START sample half a bit
   // after detection and every later sample a full bit after the previous.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cpb_d   = cpb_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      valid_d = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         RX_IDLE: begin
            if (rx_en && !rxs) begin
               cpb_d   = cpb_new;
               cnt_d   = (cpb_new >> 1) - 16'd1;
               idx_d   = 3'd0;
               state_d = RX_START;
            end
         end
         RX_START: begin
            if (cnt_q == '0) begin
               if (!rxs) begin
                  cnt_d   = cpb_q - 16'd1;
                  state_d = RX_DATA;
               end else begin
                  state_d = RX_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         RX_DATA: begin
            if (cnt_q == '0) begin
               shift_d[idx_q] = rxs;
               idx_d          = idx_q + 3'd1;
               cnt_d          = cpb_q - 16'd1;
               if (idx_q == LAST_IDX) begin
                  state_d = RX_STOP;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         RX_STOP: begin
            if (cnt_q == '0) begin
               byte_d  = shift_q;
               valid_d = 1'b1;
               err_d   = !rxs;
               state_d = rxs ? RX_IDLE : RX_BRK_WAIT;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         RX_BRK_WAIT: begin
            // A held-low line must not look like a fresh start bit.
            if (rxs) begin
               state_d = RX_IDLE;
            end
         end
         default: begin
            state_d = RX_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign o_RX_Byte   = byte_q;
   assign o_RX_Valid  = valid_q;
   assign o_Frame_Err = err_q;
   assign o_RX_Busy   = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven with ideal bit
// timing, received bytes are logged by a monitor, and each scenario checks
// byte, framing status and pulse latency against values derived from the
// frame contents and the bit period.
module tb_uart_rx;

   localparam int SYNC = 2;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        rx_en;
   logic        i_RX_Serial;
   logic [15:0] CLKS_PER_BIT;
   logic [7:0]  o_RX_Byte;
   logic        o_RX_Valid;
   logic        o_Frame_Err;
   logic        o_RX_Busy;

   uart_rx #(
      .SYNC_STAGES (SYNC),
      .MIN_CPB     (4)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rx_en        (rx_en),
      .i_RX_Serial  (i_RX_Serial),
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .o_RX_Byte    (o_RX_Byte),
      .o_RX_Valid   (o_RX_Valid),
      .o_Frame_Err  (o_Frame_Err),
      .o_RX_Busy    (o_RX_Busy)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc++;

   int checks = 0;
   int errors = 0;

   logic [7:0] got_byte[$];
   logic       got_err[$];
   int         got_cyc[$];
   int         busy_cnt = 0;
   int         stray_err = 0;

   always @(negedge clk_i) begin
      if (o_RX_Valid) begin
         got_byte.push_back(o_RX_Byte);
         got_err.push_back(o_Frame_Err);
         got_cyc.push_back(cyc);
      end
      if (o_Frame_Err && !o_RX_Valid) stray_err++;
      if (o_RX_Busy) busy_cnt++;
   end

   // Cycles from driving the start edge to the valid pulse: synchronizer
   // delay, half a bit to mid start, 9 more bits to mid stop, one to publish.
   function automatic int exp_lat(input int cpb_eff);
      return SYNC + cpb_eff / 2 + 9 * cpb_eff + 1;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int bitlen,
                             input int nbits, output int start_cyc);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      start_cyc = cyc;
      for (int i = 0; i < nbits; i++) begin
         i_RX_Serial = f[i];
         tick(bitlen);
      end
   endtask

   task automatic pop_rx(output logic ok, output logic [7:0] b, output logic e, output int c);
      if (got_byte.size() > 0) begin
         ok = 1'b1;
         b  = got_byte.pop_front();
         e  = got_err.pop_front();
         c  = got_cyc.pop_front();
      end else begin
         ok = 1'b0;
         b  = 8'h00;
         e  = 1'b0;
         c  = 0;
      end
   endtask

   task automatic clear_log();
      got_byte.delete();
      got_err.delete();
      got_cyc.delete();
   endtask

   task automatic test_reset();
      rst_i        = 1'b1;
      rx_en        = 1'b0;
      i_RX_Serial  = 1'b1;
      CLKS_PER_BIT = 16'd16;
      tick(3);
      rst_i = 1'b0;
      tick(2);
      checks++;
      if (o_RX_Byte !== 8'h00) begin
         errors++; $display("FAIL reset_byte: got %h want 00", o_RX_Byte);
      end
      checks++;
      if ({o_RX_Valid, o_Frame_Err, o_RX_Busy} !== 3'b000) begin
         errors++; $display("FAIL reset_flags: got v/e/b=%b%b%b want 000", o_RX_Valid, o_Frame_Err, o_RX_Busy);
      end
      clear_log();
   endtask

   task automatic test_ideal_frame();
      int s, c;
      logic ok, e;
      logic [7:0] b;
      rx_en = 1'b1;
      CLKS_PER_BIT = 16'd16;
      clear_log();
      send_frame(8'hA5, 1'b1, 16, 10, s);
      tick(20);
      checks++;
      if (got_byte.size() != 1) begin
         errors++; $display("FAIL ideal_count: got %0d valids want 1", got_byte.size());
      end
      pop_rx(ok, b, e, c);
      checks++;
      if (!ok || b !== 8'hA5 || e !== 1'b0) begin
         errors++; $display("FAIL ideal_byte: got %h err=%b want a5 err=0", b, e);
      end
      checks++;
      if (c - s != exp_lat(16)) begin
         errors++; $display("FAIL ideal_latency: got %0d want %0d", c - s, exp_lat(16));
      end
   endtask

   task automatic run_batch(input logic [7:0] data[], input int cpb, input string tag);
      int starts[$];
      int s, c;
      logic ok, e;
      logic [7:0] b;
      CLKS_PER_BIT = 16'(cpb);
      clear_log();
      foreach (data[i]) begin
         send_frame(data[i], 1'b1, cpb, 10, s);
         starts.push_back(s);
      end
      tick(2 * cpb + 10);
      checks++;
      if (got_byte.size() != data.size()) begin
         errors++; $display("FAIL %s_count: got %0d valids want %0d", tag, got_byte.size(), data.size());
      end
      foreach (data[i]) begin
         pop_rx(ok, b, e, c);
         checks++;
         if (!ok || b !== data[i] || e !== 1'b0) begin
            errors++; $display("FAIL %s_byte%0d: got %h err=%b want %h err=0", tag, i, b, e, data[i]);
         end
         checks++;
         if (c - starts[i] != exp_lat(cpb)) begin
            errors++; $display("FAIL %s_latency%0d: got %0d want %0d (cpb %0d)", tag, i, c - starts[i], exp_lat(cpb), cpb);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] fixed[] = '{8'h00, 8'hFF, 8'h55};
      logic [7:0] rnd[];
      int cpb;
      run_batch(fixed, 16, "b2b_fixed");
      for (int r = 0; r < 3; r++) begin
         rnd = new[4];
         foreach (rnd[i]) rnd[i] = 8'($urandom);
         cpb = $urandom_range(4, 23);
         run_batch(rnd, cpb, "b2b_rand");
      end
   endtask

   task automatic test_glitch();
      CLKS_PER_BIT = 16'd16;
      clear_log();
      busy_cnt    = 0;
      i_RX_Serial = 1'b0;
      tick(3);
      i_RX_Serial = 1'b1;
      tick(40);
      checks++;
      if (got_byte.size() != 0) begin
         errors++; $display("FAIL glitch_valid: got %0d valids want 0", got_byte.size());
      end
      checks++;
      if (busy_cnt != 8) begin
         errors++; $display("FAIL glitch_busy: busy for %0d cycles want 8", busy_cnt);
      end
   endtask

   task automatic test_frame_err();
      int s, c;
      logic ok, e;
      logic [7:0] b;
      CLKS_PER_BIT = 16'd16;
      clear_log();
      stray_err = 0;
      send_frame(8'h3C, 1'b0, 16, 10, s);
      tick(40);
      checks++;
      if (got_byte.size() != 1) begin
         errors++; $display("FAIL ferr_count: got %0d valids want 1", got_byte.size());
      end
      pop_rx(ok, b, e, c);
      checks++;
      if (!ok || b !== 8'h3C || e !== 1'b1) begin
         errors++; $display("FAIL ferr_byte: got %h err=%b want 3c err=1", b, e);
      end
      checks++;
      if (c - s != exp_lat(16)) begin
         errors++; $display("FAIL ferr_latency: got %0d want %0d", c - s, exp_lat(16));
      end
      checks++;
      if (o_RX_Busy !== 1'b1) begin
         errors++; $display("FAIL break_busy: got %b want 1", o_RX_Busy);
      end
      i_RX_Serial = 1'b1;
      tick(10);
      checks++;
      if (o_RX_Busy !== 1'b0 || got_byte.size() != 0) begin
         errors++; $display("FAIL break_release: busy=%b valids=%0d want 0/0", o_RX_Busy, got_byte.size());
      end
      send_frame(8'h81, 1'b1, 16, 10, s);
      tick(20);
      pop_rx(ok, b, e, c);
      checks++;
      if (!ok || b !== 8'h81 || e !== 1'b0 || got_byte.size() != 0) begin
         errors++; $display("FAIL after_break: got ok=%b %h err=%b want 81 err=0", ok, b, e);
      end
      checks++;
      if (stray_err != 0) begin
         errors++; $display("FAIL err_without_valid: got %0d want 0", stray_err);
      end
   endtask

   task automatic test_clamp();
      int s, c;
      logic ok, e;
      logic [7:0] b;
      CLKS_PER_BIT = 16'd2;
      clear_log();
      send_frame(8'h96, 1'b1, 4, 10, s);
      tick(20);
      pop_rx(ok, b, e, c);
      checks++;
      if (!ok || b !== 8'h96 || e !== 1'b0 || got_byte.size() != 0) begin
         errors++; $display("FAIL clamp_byte: got ok=%b %h err=%b want 96 err=0", ok, b, e);
      end
      checks++;
      if (c - s != exp_lat(4)) begin
         errors++; $display("FAIL clamp_latency: got %0d want %0d", c - s, exp_lat(4));
      end
      CLKS_PER_BIT = 16'd16;
   endtask

   task automatic test_rx_en();
      int s, c;
      logic ok, e;
      logic [7:0] b, d;
      CLKS_PER_BIT = 16'd16;
      clear_log();
      rx_en    = 1'b0;
      busy_cnt = 0;
      d = 8'($urandom);
      send_frame(d, 1'b1, 16, 10, s);
      tick(20);
      checks++;
      if (got_byte.size() != 0 || busy_cnt != 0) begin
         errors++; $display("FAIL disabled: valids=%0d busy=%0d want 0/0", got_byte.size(), busy_cnt);
      end
      // Dropping rx_en and changing the divisor mid-frame must not disturb it.
      rx_en = 1'b1;
      d = 8'($urandom);
      fork
         send_frame(d, 1'b1, 16, 10, s);
         begin
            tick(50);
            rx_en        = 1'b0;
            CLKS_PER_BIT = 16'd7;
         end
      join
      tick(20);
      pop_rx(ok, b, e, c);
      checks++;
      if (!ok || b !== d || e !== 1'b0) begin
         errors++; $display("FAIL en_midframe: got ok=%b %h err=%b want %h err=0", ok, b, e, d);
      end
      checks++;
      if (c - s != exp_lat(16)) begin
         errors++; $display("FAIL en_midframe_latency: got %0d want %0d", c - s, exp_lat(16));
      end
      rx_en        = 1'b1;
      CLKS_PER_BIT = 16'd16;
   endtask

   task automatic test_reset_mid();
      int s, c;
      logic ok, e;
      logic [7:0] b;
      CLKS_PER_BIT = 16'd16;
      clear_log();
      send_frame(8'hC3, 1'b1, 16, 6, s);
      rst_i = 1'b1;
      tick(1);
      checks++;
      if (o_RX_Busy !== 1'b0 || o_RX_Valid !== 1'b0 || o_RX_Byte !== 8'h00) begin
         errors++; $display("FAIL reset_mid: busy=%b valid=%b byte=%h want 0/0/00", o_RX_Busy, o_RX_Valid, o_RX_Byte);
      end
      rst_i       = 1'b0;
      i_RX_Serial = 1'b1;
      tick(200);
      checks++;
      if (got_byte.size() != 0) begin
         errors++; $display("FAIL reset_mid_pulse: got %0d valids want 0", got_byte.size());
      end
      send_frame(8'h12, 1'b1, 16, 10, s);
      tick(20);
      pop_rx(ok, b, e, c);
      checks++;
      if (!ok || b !== 8'h12 || e !== 1'b0 || c - s != exp_lat(16)) begin
         errors++; $display("FAIL after_reset: got ok=%b %h err=%b lat=%0d want 12 err=0 lat=%0d", ok, b, e, c - s, exp_lat(16));
      end
   endtask

   initial begin
      test_reset();
      test_ideal_frame();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_clamp();
      test_rx_en();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
